exception_trigger_unit: RTL and testbench
=========================================

Name: exception_trigger_unit

Overview:
Parametrised exception collection and delivery unit between the pipeline stages and the controller sequencer. It latches per-source exception triggers and built-in alignment violations into a pending vector, applies a mask, selects the highest-priority pending source and presents it to the controller with a registered valid/ready handshake. Once delivered it blocks further delivery until the handler signals return. All state updates are gated by the pipeline stall enable.

Parameters:
NUM_SRC, 8, number of exception sources; index 0 is highest priority and non-maskable; minimum 2
CAUSE_W, 5, width of exc_cause; must satisfy 2^CAUSE_W >= CAUSE_BASE+NUM_SRC
CAUSE_BASE, 0, cause code emitted for source 0; source i emits CAUSE_BASE+i
ADDR_LSB, 3, number of address low bits checked for alignment; supports accesses up to 2^ADDR_LSB bytes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  stall gate; 0 freezes every register
src_trig  in  NUM_SRC  per-source trigger pulses, sampled when enable=1
src_mask  in  NUM_SRC  1 = source may be delivered; bit 0 is ignored
align_valid  in  1  an alignment check is requested this cycle
align_addr  in  ADDR_LSB  low address bits of the access
align_size  in  2  log2 of access size in bytes (0=1B, 1=2B, 2=4B, 3=8B)
align_src  in  $clog2(NUM_SRC)  source index raised on misalignment (fetch or data)
flush  in  1  discard all pending exceptions
exc_return  in  1  handler finished; re-arm delivery
exc_valid  out  1  exception presented to controller
exc_cause  out  CAUSE_W  cause code of the presented exception
exc_ready  in  1  controller accepts the presented exception
pending  out  NUM_SRC  current pending vector, for status readback
in_service  out  1  high while in state SERVICE

Behaviour:
- Reset: pending=0, state=IDLE, exc_valid=0, exc_cause=0, in_service=0.
- enable=0: all registers hold, including pending, the FSM and the outputs. Inputs are ignored.
- Misalignment (combinational): mis = align_valid & (align_size > ADDR_LSB, or the low align_size bits of align_addr are nonzero). Size 0 is never misaligned.
- set_vec = src_trig, OR-ed with a one-hot bit at align_src when mis=1.
- eligible = pending & (src_mask | 1). Bit 0 is always eligible.
- sel = lowest-index set bit of eligible.
- Pending update, when enable=1, in priority order:
  - flush=1: pending <= 0. Flush wins over same-cycle triggers.
  - otherwise: pending <= (pending & ~clr_vec) | set_vec, where clr_vec is the one-hot of the delivered source on a handshake cycle. A same-cycle re-trigger of that source re-pends it (set wins).
- FSM (advances only when enable=1):
  - IDLE: if eligible != 0 and flush=0 -> REQ; register exc_valid<=1 and exc_cause<=CAUSE_BASE+sel.
  - REQ: exc_valid=1. exc_cause is re-evaluated each cycle, so a higher-priority source arriving may pre-empt before acceptance.
    - exc_valid & exc_ready -> SERVICE; clear that source's pending bit; exc_valid<=0.
    - flush=1 without exc_ready -> IDLE; exc_valid<=0.
    - If the selected source becomes masked and nothing is eligible -> IDLE; exc_valid<=0.
  - SERVICE: in_service=1. New triggers still latch into pending; no delivery.
    - exc_return -> IDLE. A delivery may start in the following cycle.
    - exception: if pending[0] sets during SERVICE, go directly to REQ (nested non-maskable exception); in_service stays 1 until the next exc_return.
- Handshake latency: a trigger at cycle N sets pending at N+1 and raises exc_valid at N+2 from IDLE.
- exc_ready while exc_valid=0 has no effect. exc_return outside SERVICE is ignored.
- reset mid-operation returns immediately to the reset values, with pending lost.
- Width rule: exc_cause = CAUSE_BASE + sel, truncated to CAUSE_W. A parameter check errors if it does not fit.

Test Plan:
- reset, src_trig=8'b0000_0100, mask=FF -> pending=04 at N+1, exc_valid=1 with cause=2 at N+2; exc_ready=1 -> pending=00, in_service=1; exc_return -> IDLE.
- align_valid, size=2, addr=3'b010, align_src=5 -> pending[5]=1, cause=5. The same with addr=3'b100 -> no pending. size=3 with addr=3'b000 -> no pending.
- src_trig=0x30 with mask=0xDF -> cause=4 delivered first; after return with mask=FF -> cause=5 delivered.
- in REQ with cause=6, src_trig[1] pulses before ready -> cause becomes 1 and ready delivers 1; pending[6] remains set.
- in SERVICE, src_trig[0] pulses -> exc_valid=1, cause=0 without exc_return; flush in REQ -> exc_valid=0, pending=0.
- enable=0 held for 3 cycles with triggers and ready active -> all outputs and pending unchanged; with enable=1 the sequence resumes.

Source files
------------

// File: rtl/exception_trigger_unit.sv
// Collects exception triggers and alignment faults into a pending vector, then delivers the
// highest-priority unmasked source over a registered valid/ready handshake and blocks until return.
module exception_trigger_unit #(
    parameter int NUM_SRC    = 8,
    parameter int CAUSE_W    = 5,
    parameter int CAUSE_BASE = 0,
    parameter int ADDR_LSB   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         src_trig,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic                       align_valid,
    input  logic [ADDR_LSB-1:0]        align_addr,
    input  logic [1:0]                 align_size,
    input  logic [$clog2(NUM_SRC)-1:0] align_src,
    input  logic                       flush,
    input  logic                       exc_return,
    output logic                       exc_valid,
    output logic [CAUSE_W-1:0]         exc_cause,
    input  logic                       exc_ready,
    output logic [NUM_SRC-1:0]         pending,
    output logic                       in_service
);

    localparam int SRC_W = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || (64'(1) << CAUSE_W) < 64'(CAUSE_BASE + NUM_SRC)) begin : g_bad_param
        $error("exception_trigger_unit: NUM_SRC must be >= 2 and every cause code must fit in CAUSE_W");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [NUM_SRC-1:0]   pending_d;
    logic                 valid_d;
    logic [CAUSE_W-1:0]   cause_d;
    logic [SRC_W-1:0]     cur_src, cur_src_d;
    logic                 svc_d;

    logic                 mis;
    logic                 low_bad;
    logic [NUM_SRC-1:0]   set_vec;
    logic [NUM_SRC-1:0]   clr_vec;
    logic [NUM_SRC-1:0]   eligible;
    logic [SRC_W-1:0]     sel;
    logic [CAUSE_W-1:0]   cause_sel;
    logic                 handshake;

    // Only address bits below the access size must be zero; size 0 can never fault.
    always_comb begin
        low_bad = 1'b0;
        for (int i = 0; i < ADDR_LSB; i++) begin
            if (align_addr[i] && (i < int'(align_size)))
                low_bad = 1'b1;
        end
        mis = align_valid & ((int'(align_size) > ADDR_LSB) | low_bad);
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            set_vec[i] = src_trig[i] | (mis && (int'(align_src) == i));
    end

    assign eligible = pending & (src_mask | NUM_SRC'(1));

    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i])
                sel = SRC_W'(i);
        end
    end

    assign cause_sel = CAUSE_W'(CAUSE_BASE + int'(sel));
    assign handshake = exc_valid & exc_ready;
    // The source cleared on acceptance is the one actually presented, not the current winner.
    assign clr_vec   = handshake ? (NUM_SRC'(1) << cur_src) : '0;

    always_comb begin
        state_d   = state;
        valid_d   = exc_valid;
        cause_d   = exc_cause;
        cur_src_d = cur_src;
        svc_d     = in_service;
        pending_d = flush ? '0 : ((pending & ~clr_vec) | set_vec);

        case (state)
            IDLE: begin
                if ((|eligible) && !flush) begin
                    state_d   = REQ;
                    valid_d   = 1'b1;
                    cause_d   = cause_sel;
                    cur_src_d = sel;
                end
            end
            REQ: begin
                if (handshake) begin
                    state_d = SERVICE;
                    valid_d = 1'b0;
                    svc_d   = 1'b1;
                end else if (flush || !(|eligible)) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    svc_d   = 1'b0;
                end else begin
                    cause_d   = cause_sel;
                    cur_src_d = sel;
                end
            end
            SERVICE: begin
                if (exc_return) begin
                    state_d = IDLE;
                    svc_d   = 1'b0;
                end else if (pending[0] && !flush) begin
                    // Nested non-maskable exception; the handler is still active.
                    state_d   = REQ;
                    valid_d   = 1'b1;
                    cause_d   = CAUSE_W'(CAUSE_BASE);
                    cur_src_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                svc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            exc_valid  <= 1'b0;
            exc_cause  <= '0;
            cur_src    <= '0;
            in_service <= 1'b0;
        end else if (enable) begin
            state      <= state_d;
            pending    <= pending_d;
            exc_valid  <= valid_d;
            exc_cause  <= cause_d;
            cur_src    <= cur_src_d;
            in_service <= svc_d;
        end
    end

endmodule

// File: tb/tb_exception_trigger_unit.sv
// Directed bench: expected causes are queued at stimulus time and checked by a handshake monitor.
module tb_exception_trigger_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] src_trig;
    logic [7:0] src_mask;
    logic       align_valid;
    logic [2:0] align_addr;
    logic [1:0] align_size;
    logic [2:0] align_src;
    logic       flush;
    logic       exc_return;
    logic       exc_valid;
    logic [4:0] exc_cause;
    logic       exc_ready;
    logic [7:0] pending;
    logic       in_service;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];

    exception_trigger_unit #(
        .NUM_SRC(8), .CAUSE_W(5), .CAUSE_BASE(0), .ADDR_LSB(3)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .src_trig(src_trig), .src_mask(src_mask),
        .align_valid(align_valid), .align_addr(align_addr),
        .align_size(align_size), .align_src(align_src),
        .flush(flush), .exc_return(exc_return),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_ready(exc_ready),
        .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted exception must match the oldest expected cause.
    always @(negedge clk) begin
        if (!reset && enable && exc_valid && exc_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: accepted cause=%0d but none expected", exc_cause);
            end else begin
                automatic int unsigned e = exp_q.pop_front();
                if (32'(exc_cause) != e) begin
                    bad++;
                    $display("FAIL scoreboard: accepted cause=%0d expected %0d", exc_cause, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] t);
        src_trig = t;
        tick();
        src_trig = '0;
    endtask

    task automatic deliver(input int unsigned cause);
        exp_q.push_back(cause);
        exc_ready = 1'b1;
        tick();
        exc_ready = 1'b0;
    endtask

    task automatic ret();
        exc_return = 1'b1;
        tick();
        exc_return = 1'b0;
    endtask

    task automatic align(input logic [1:0] sz, input logic [2:0] addr, input logic [2:0] src);
        align_valid = 1'b1;
        align_size  = sz;
        align_addr  = addr;
        align_src   = src;
        tick();
        align_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; src_trig = '0; src_mask = 8'hFF;
        align_valid = 1'b0; align_addr = '0; align_size = '0; align_src = '0;
        flush = 1'b0; exc_return = 1'b0; exc_ready = 1'b0;
        tick(); tick();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_valid", 32'(exc_valid), 32'h0);
        chk("rst_cause", 32'(exc_cause), 32'h0);
        chk("rst_in_service", 32'(in_service), 32'h0);
        reset = 1'b0;
        tick();

        // Basic trigger: pending at N+1, valid at N+2.
        pulse(8'h04);
        chk("t1_pending", 32'(pending), 32'h04);
        chk("t1_valid_early", 32'(exc_valid), 32'h0);
        tick();
        chk("t1_valid", 32'(exc_valid), 32'h1);
        chk("t1_cause", 32'(exc_cause), 32'd2);
        deliver(2);
        chk("t1_pending_clr", 32'(pending), 32'h00);
        chk("t1_in_service", 32'(in_service), 32'h1);
        chk("t1_valid_drop", 32'(exc_valid), 32'h0);
        ret();
        chk("t1_returned", 32'(in_service), 32'h0);

        // Alignment checks.
        align(2'd2, 3'b010, 3'd5);
        chk("al_mis_pending", 32'(pending), 32'h20);
        tick();
        chk("al_mis_cause", 32'(exc_cause), 32'd5);
        deliver(5);
        ret();
        align(2'd2, 3'b100, 3'd5);
        chk("al_ok4_pending", 32'(pending), 32'h00);
        align(2'd3, 3'b000, 3'd5);
        chk("al_ok8_pending", 32'(pending), 32'h00);
        tick();
        chk("al_ok_valid", 32'(exc_valid), 32'h0);

        // Masking: bit 5 held off until the mask opens.
        src_mask = 8'hDF;
        pulse(8'h30);
        chk("mk_pending", 32'(pending), 32'h30);
        tick();
        chk("mk_cause4", 32'(exc_cause), 32'd4);
        deliver(4);
        chk("mk_pending_left", 32'(pending), 32'h20);
        ret();
        tick();
        chk("mk_blocked", 32'(exc_valid), 32'h0);
        src_mask = 8'hFF;
        tick();
        chk("mk_cause5", 32'(exc_cause), 32'd5);
        deliver(5);
        ret();

        // Pre-emption in REQ by a higher-priority source.
        pulse(8'h40);
        tick();
        chk("pe_cause6", 32'(exc_cause), 32'd6);
        pulse(8'h02);
        tick();
        chk("pe_cause1", 32'(exc_cause), 32'd1);
        deliver(1);
        chk("pe_pending6", 32'(pending), 32'h40);
        ret();
        tick();
        chk("pe_cause6_again", 32'(exc_cause), 32'd6);
        deliver(6);

        // Nested non-maskable source while in SERVICE.
        pulse(8'h01);
        chk("ns_pending0", 32'(pending), 32'h01);
        chk("ns_no_valid", 32'(exc_valid), 32'h0);
        tick();
        chk("ns_valid", 32'(exc_valid), 32'h1);
        chk("ns_cause0", 32'(exc_cause), 32'd0);
        chk("ns_in_service", 32'(in_service), 32'h1);
        deliver(0);
        ret();
        chk("ns_done", 32'(in_service), 32'h0);

        // Flush while requesting.
        pulse(8'h08);
        tick();
        chk("fl_valid", 32'(exc_valid), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid_drop", 32'(exc_valid), 32'h0);
        chk("fl_pending", 32'(pending), 32'h00);
        tick();
        chk("fl_idle", 32'(exc_valid), 32'h0);

        // Asynchronous reset mid-request.
        pulse(8'h08);
        tick();
        reset = 1'b1;
        #1;
        chk("rm_pending", 32'(pending), 32'h00);
        chk("rm_valid", 32'(exc_valid), 32'h0);
        chk("rm_cause", 32'(exc_cause), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Stall: all state frozen with enable low.
        pulse(8'h04);
        tick();
        chk("st_valid_pre", 32'(exc_valid), 32'h1);
        enable = 1'b0; src_trig = 8'hFF; exc_ready = 1'b1; exc_return = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_pending", 32'(pending), 32'h04);
            chk("st_valid", 32'(exc_valid), 32'h1);
            chk("st_cause", 32'(exc_cause), 32'd2);
            chk("st_in_service", 32'(in_service), 32'h0);
        end
        src_trig = '0; exc_return = 1'b0; flush = 1'b0; exc_ready = 1'b0;
        enable = 1'b1;
        deliver(2);
        chk("st_resume_svc", 32'(in_service), 32'h1);
        chk("st_resume_pending", 32'(pending), 32'h00);
        ret();
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
